// File: rtl/simd_mem_pkg.sv
// rtl/simd_mem_pkg.sv - shared types and RAM geometry for the vector data-RAM arbiter
package simd_mem_pkg;

  localparam int RAM_AW  = 14;
  localparam int RAM_DW  = 256;
  localparam int RAM_BEW = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} arb_state_t;
  typedef enum logic {REQ_P, REQ_L} req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_P) ? REQ_L : REQ_P;
  endfunction

endpackage

// File: rtl/simd_rr_arbiter2.sv
// rtl/simd_rr_arbiter2.sv - two-way round-robin pick with a registered last-grant pointer
module simd_rr_arbiter2
  import simd_mem_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    req_p,
  input  logic    req_l,
  input  logic    take,
  output logic    valid,
  output req_id_t winner
);

  req_id_t last_q, last_d;

  always_comb begin
    valid = req_p | req_l;
    if (req_p && req_l) begin
      winner = other_req(last_q);
    end else if (req_p) begin
      winner = REQ_P;
    end else begin
      winner = REQ_L;
    end
    last_d = last_q;
    if (take && valid) begin
      last_d = winner;
    end
  end

  // Pointer starts at L so that P wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= REQ_L;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/simd_mem_arbiter.sv
// rtl/simd_mem_arbiter.sv - arbitrates the 256-bit vector data-RAM port between processor (P) and loader (L)
// Define SIMD_ARB_PERF_EN to add saturating grant and conflict counters.
module simd_mem_arbiter
  import simd_mem_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int AW     = RAM_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_p,
  input  logic               req_l,
  input  logic               we_p,
  input  logic               we_l,
  input  logic [AW-1:0]      addr_p,
  input  logic [AW-1:0]      addr_l,
  input  logic [RAM_BEW-1:0] byteena_p,
  input  logic [RAM_BEW-1:0] byteena_l,
  input  logic [RAM_DW-1:0]  wdata_p,
  input  logic [RAM_DW-1:0]  wdata_l,
  output logic               gnt_p,
  output logic               gnt_l,
  output logic               rvalid_p,
  output logic               rvalid_l,
  output logic [RAM_DW-1:0]  rdata,
  output logic               busy,
  output logic [AW-1:0]      address_RAM,
  output logic [RAM_BEW-1:0] byteena_RAM,
  output logic [RAM_DW-1:0]  writeData_RAM,
  output logic               rden_RAM,
  output logic               wren_RAM,
  input  logic [RAM_DW-1:0]  readData_RAM
`ifdef SIMD_ARB_PERF_EN
  ,
  output logic [31:0]        cnt_p,
  output logic [31:0]        cnt_l,
  output logic [31:0]        cnt_conflict
`endif
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  arb_state_t         state_q, state_d;
  req_id_t            owner_q, owner_d, arb_winner;
  logic               arb_valid, arb_take;
  logic [2:0]         lat_q, lat_d;
  logic               gnt_p_q, gnt_p_d, gnt_l_q, gnt_l_d;
  logic               rvalid_p_q, rvalid_p_d, rvalid_l_q, rvalid_l_d;
  logic               rden_q, rden_d, wren_q, wren_d;
  logic [RAM_DW-1:0]  rdata_q, rdata_d, wdata_q, wdata_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [RAM_BEW-1:0] be_q, be_d;

  logic               sel_p, sel_we;
  logic [AW-1:0]      sel_addr;
  logic [RAM_BEW-1:0] sel_be;
  logic [RAM_DW-1:0]  sel_wdata;

  simd_rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req_p  (req_p),
    .req_l  (req_l),
    .take   (arb_take),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  assign arb_take  = (state_q == IDLE);
  assign sel_p     = (arb_winner == REQ_P);
  assign sel_we    = sel_p ? we_p      : we_l;
  assign sel_addr  = sel_p ? addr_p    : addr_l;
  assign sel_be    = sel_p ? byteena_p : byteena_l;
  assign sel_wdata = sel_p ? wdata_p   : wdata_l;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_d      = lat_q;
    gnt_p_d    = 1'b0;
    gnt_l_d    = 1'b0;
    rvalid_p_d = 1'b0;
    rvalid_l_d = 1'b0;
    rden_d     = 1'b0;
    wren_d     = 1'b0;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    be_d       = be_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d = arb_winner;
          gnt_p_d = sel_p;
          gnt_l_d = ~sel_p;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          // Reads present full-width enables so the RAM returns the whole word.
          be_d    = sel_we ? sel_be : '1;
          wren_d  = sel_we;
          rden_d  = ~sel_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wren_q) begin
          state_d = IDLE;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_q == 3'd0) begin
          rdata_d    = readData_RAM;
          rvalid_p_d = (owner_q == REQ_P);
          rvalid_l_d = (owner_q == REQ_L);
          state_d    = IDLE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= REQ_P;
      lat_q      <= '0;
      gnt_p_q    <= 1'b0;
      gnt_l_q    <= 1'b0;
      rvalid_p_q <= 1'b0;
      rvalid_l_q <= 1'b0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      be_q       <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_q      <= lat_d;
      gnt_p_q    <= gnt_p_d;
      gnt_l_q    <= gnt_l_d;
      rvalid_p_q <= rvalid_p_d;
      rvalid_l_q <= rvalid_l_d;
      rden_q     <= rden_d;
      wren_q     <= wren_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
    end
  end

  assign gnt_p         = gnt_p_q;
  assign gnt_l         = gnt_l_q;
  assign rvalid_p      = rvalid_p_q;
  assign rvalid_l      = rvalid_l_q;
  assign rdata         = rdata_q;
  assign busy          = (state_q != IDLE);
  assign address_RAM   = addr_q;
  assign byteena_RAM   = be_q;
  assign writeData_RAM = wdata_q;
  assign rden_RAM      = rden_q;
  assign wren_RAM      = wren_q;

`ifdef SIMD_ARB_PERF_EN
  logic [31:0] cnt_p_q, cnt_p_d, cnt_l_q, cnt_l_d, cnt_conf_q, cnt_conf_d;

  always_comb begin
    cnt_p_d    = cnt_p_q;
    cnt_l_d    = cnt_l_q;
    cnt_conf_d = cnt_conf_q;
    if (gnt_p_d && (cnt_p_q != '1)) cnt_p_d = cnt_p_q + 32'd1;
    if (gnt_l_d && (cnt_l_q != '1)) cnt_l_d = cnt_l_q + 32'd1;
    if ((state_q == IDLE) && req_p && req_l && (cnt_conf_q != '1)) begin
      cnt_conf_d = cnt_conf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p_q    <= '0;
      cnt_l_q    <= '0;
      cnt_conf_q <= '0;
    end else begin
      cnt_p_q    <= cnt_p_d;
      cnt_l_q    <= cnt_l_d;
      cnt_conf_q <= cnt_conf_d;
    end
  end

  assign cnt_p        = cnt_p_q;
  assign cnt_l        = cnt_l_q;
  assign cnt_conflict = cnt_conf_q;
`endif

endmodule

// File: tb/tb_simd_mem_arbiter.sv
// tb/tb_simd_mem_arbiter.sv - self-checking bench for simd_mem_arbiter with a behavioural RAM and reference model
module tb_simd_mem_arbiter;
  import simd_mem_pkg::*;

  localparam int RD_LAT = 2;
  localparam int AW     = 14;
  localparam logic [RAM_DW-1:0] PAT_A = {4{64'hDEAD_BEEF_0123_4567}};

  typedef struct {
    int                edge_n;
    bit                is_p;
    logic [RAM_DW-1:0] data;
  } rv_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               req_p, req_l, we_p, we_l;
  logic [AW-1:0]      addr_p, addr_l;
  logic [RAM_BEW-1:0] byteena_p, byteena_l;
  logic [RAM_DW-1:0]  wdata_p, wdata_l;
  logic               gnt_p, gnt_l, rvalid_p, rvalid_l, busy;
  logic [RAM_DW-1:0]  rdata;
  logic [AW-1:0]      address_RAM;
  logic [RAM_BEW-1:0] byteena_RAM;
  logic [RAM_DW-1:0]  writeData_RAM;
  logic               rden_RAM, wren_RAM;
  logic [RAM_DW-1:0]  readData_RAM;
`ifdef SIMD_ARB_PERF_EN
  logic [31:0]        cnt_p, cnt_l, cnt_conflict;
`endif

  logic [RAM_DW-1:0]  ram     [0:(1<<AW)-1];
  logic [RAM_DW-1:0]  exp_mem [0:(1<<AW)-1];
  logic [RAM_DW-1:0]  rpipe   [0:RD_LAT-1];
  logic [AW-1:0]      pool    [0:7];

  int passed = 0;
  int total  = 0;
  bit last_p = 1'b0;

  always #5 clk = ~clk;

  simd_mem_arbiter #(.RD_LAT(RD_LAT), .AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_p         (req_p),
    .req_l         (req_l),
    .we_p          (we_p),
    .we_l          (we_l),
    .addr_p        (addr_p),
    .addr_l        (addr_l),
    .byteena_p     (byteena_p),
    .byteena_l     (byteena_l),
    .wdata_p       (wdata_p),
    .wdata_l       (wdata_l),
    .gnt_p         (gnt_p),
    .gnt_l         (gnt_l),
    .rvalid_p      (rvalid_p),
    .rvalid_l      (rvalid_l),
    .rdata         (rdata),
    .busy          (busy),
    .address_RAM   (address_RAM),
    .byteena_RAM   (byteena_RAM),
    .writeData_RAM (writeData_RAM),
    .rden_RAM      (rden_RAM),
    .wren_RAM      (wren_RAM),
    .readData_RAM  (readData_RAM)
`ifdef SIMD_ARB_PERF_EN
    ,
    .cnt_p         (cnt_p),
    .cnt_l         (cnt_l),
    .cnt_conflict  (cnt_conflict)
`endif
  );

  function automatic logic [RAM_DW-1:0] merge(input logic [RAM_DW-1:0] old_v,
                                              input logic [RAM_DW-1:0] new_v,
                                              input logic [RAM_BEW-1:0] be);
    for (int b = 0; b < RAM_BEW; b++) begin
      if (be[b]) old_v[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return old_v;
  endfunction

  function automatic logic [RAM_DW-1:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // RAM: write at the strobe edge; read word readable RD_LAT edges after rden is sampled, garbage otherwise.
  always @(posedge clk) begin
    if (wren_RAM) ram[address_RAM] <= merge(ram[address_RAM], writeData_RAM, byteena_RAM);
    rpipe[0] <= rden_RAM ? ram[address_RAM] : rand256();
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign readData_RAM = rpipe[RD_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_p = 0; req_l = 0; we_p = 0; we_l = 0; addr_p = '0; addr_l = '0;
    byteena_p = '0; byteena_l = '0; wdata_p = '0; wdata_l = '0;
    repeat (2) tick();
    total++;
    if ({gnt_p, gnt_l, rvalid_p, rvalid_l, busy, rden_RAM, wren_RAM} !== 7'b0 || address_RAM !== '0 ||
        byteena_RAM !== '0 || writeData_RAM !== '0 || rdata !== '0)
      $display("FAIL reset_state: ctl=%b addr=%h be=%h wd_zero=%0d rd_zero=%0d required all zero",
               {gnt_p, gnt_l, rvalid_p, rvalid_l, busy, rden_RAM, wren_RAM}, address_RAM, byteena_RAM,
               writeData_RAM == '0, rdata == '0);
    else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write();
    req_p = 1; we_p = 1; addr_p = 14'h0010; byteena_p = 32'hFFFF_FFFF; wdata_p = PAT_A;
    tick();
    total++;
    if ({gnt_p, gnt_l, wren_RAM, rden_RAM, busy} !== 5'b10101 || address_RAM !== 14'h0010 ||
        byteena_RAM !== 32'hFFFF_FFFF || writeData_RAM !== PAT_A)
      $display("FAIL write_issue: gnt_p/gnt_l/wren/rden/busy=%b addr=%h be=%h required 10101 addr=0010 be=ffffffff",
               {gnt_p, gnt_l, wren_RAM, rden_RAM, busy}, address_RAM, byteena_RAM);
    else passed++;
    exp_mem[14'h0010] = PAT_A;
    last_p = 1;
    req_p = 0;
    tick();
    total++;
    if ({gnt_p, wren_RAM, rden_RAM, busy} !== 4'b0)
      $display("FAIL write_done: gnt_p/wren/rden/busy=%b required 0000", {gnt_p, wren_RAM, rden_RAM, busy});
    else passed++;
  endtask

  task automatic test_preload();
    for (int i = 0; i < 8; i++) begin
      req_l = 1; we_l = 1; addr_l = pool[i]; byteena_l = 32'hFFFF_FFFF; wdata_l = rand256();
      tick();
      total++;
      if ({gnt_l, gnt_p, wren_RAM} !== 3'b101 || address_RAM !== pool[i])
        $display("FAIL preload_%0d: gnt_l/gnt_p/wren=%b addr=%h required 101 addr=%h",
                 i, {gnt_l, gnt_p, wren_RAM}, address_RAM, pool[i]);
      else passed++;
      exp_mem[pool[i]] = wdata_l;
      req_l = 0;
      tick();
    end
    last_p = 0;
  endtask

  task automatic test_read();
    req_l = 1; we_l = 0; addr_l = 14'h3FFF; byteena_l = '0; wdata_l = rand256();
    tick();
    total++;
    if ({gnt_l, gnt_p, rden_RAM, wren_RAM} !== 4'b1010 || address_RAM !== 14'h3FFF || byteena_RAM !== 32'hFFFF_FFFF)
      $display("FAIL read_issue: gnt_l/gnt_p/rden/wren=%b addr=%h be=%h required 1010 addr=3fff be=ffffffff",
               {gnt_l, gnt_p, rden_RAM, wren_RAM}, address_RAM, byteena_RAM);
    else passed++;
    req_l = 0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      tick();
      total++;
      if ({rvalid_p, rvalid_l, rden_RAM, busy} !== {1'b0, k == RD_LAT + 1, 1'b0, k < RD_LAT + 1} ||
          address_RAM !== 14'h3FFF)
        $display("FAIL read_wait_%0d: rvalid_p/rvalid_l/rden/busy=%b addr=%h required %b addr=3fff",
                 k, {rvalid_p, rvalid_l, rden_RAM, busy}, address_RAM, {1'b0, k == RD_LAT + 1, 1'b0, k < RD_LAT + 1});
      else passed++;
    end
    total++;
    if (rdata !== exp_mem[14'h3FFF])
      $display("FAIL read_data: rdata=%h required %h", rdata, exp_mem[14'h3FFF]);
    else passed++;
    tick();
    total++;
    if (rvalid_l !== 1'b0 || rdata !== exp_mem[14'h3FFF])
      $display("FAIL read_hold: rvalid_l=%b rdata=%h required 0 and %h", rvalid_l, rdata, exp_mem[14'h3FFF]);
    else passed++;
    last_p = 0;
  endtask

  task automatic test_round_robin();
    req_p = 1; we_p = 1; addr_p = pool[3]; byteena_p = 32'hFFFF_FFFF; wdata_p = rand256();
    req_l = 1; we_l = 1; addr_l = pool[4]; byteena_l = 32'hFFFF_FFFF; wdata_l = rand256();
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if ({gnt_p, gnt_l} !== {k % 4 == 0, k % 4 == 2})
        $display("FAIL rr_order_%0d: gnt_p/gnt_l=%b required %b", k, {gnt_p, gnt_l}, {k % 4 == 0, k % 4 == 2});
      else passed++;
    end
    exp_mem[pool[3]] = wdata_p;
    exp_mem[pool[4]] = wdata_l;
    last_p = 0;
    req_p = 0; req_l = 0;
    tick();
  endtask

  task automatic test_byteena();
    logic [RAM_DW-1:0] old_v;
    old_v = exp_mem[14'h0005];
    req_p = 1; we_p = 1; addr_p = 14'h0005; byteena_p = 32'h0000_000F; wdata_p = {32{8'hAA}};
    tick();
    total++;
    if ({gnt_p, wren_RAM} !== 2'b11 || byteena_RAM !== 32'h0000_000F || address_RAM !== 14'h0005)
      $display("FAIL be_write: gnt_p/wren=%b be=%h addr=%h required 11 be=0000000f addr=0005",
               {gnt_p, wren_RAM}, byteena_RAM, address_RAM);
    else passed++;
    exp_mem[14'h0005] = {old_v[255:32], 32'hAAAA_AAAA};
    req_p = 0;
    tick();
    req_p = 1; we_p = 0;
    tick();
    total++;
    if ({gnt_p, rden_RAM} !== 2'b11 || byteena_RAM !== 32'hFFFF_FFFF)
      $display("FAIL be_read_issue: gnt_p/rden=%b be=%h required 11 be=ffffffff", {gnt_p, rden_RAM}, byteena_RAM);
    else passed++;
    req_p = 0;
    repeat (RD_LAT + 1) tick();
    total++;
    if (rvalid_p !== 1'b1 || rdata !== {old_v[255:32], 32'hAAAA_AAAA})
      $display("FAIL be_read_data: rvalid_p=%b rdata=%h required 1 %h", rvalid_p, rdata, {old_v[255:32], 32'hAAAA_AAAA});
    else passed++;
    last_p = 1;
  endtask

  task automatic test_reset_mid_read();
    req_p = 1; we_p = 0; addr_p = pool[2];
    tick();
    req_p = 0;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({gnt_p, gnt_l, rvalid_p, rvalid_l, busy, rden_RAM, wren_RAM} !== 7'b0 || address_RAM !== '0 ||
        byteena_RAM !== '0 || writeData_RAM !== '0 || rdata !== '0)
      $display("FAIL midreset_state: ctl=%b addr=%h be=%h rd_zero=%0d required all zero",
               {gnt_p, gnt_l, rvalid_p, rvalid_l, busy, rden_RAM, wren_RAM}, address_RAM, byteena_RAM, rdata == '0);
    else passed++;
    tick();
    reset = 1'b1;
    for (int k = 0; k < RD_LAT + 3; k++) begin
      tick();
      total++;
      if ({rvalid_p, rvalid_l, busy} !== 3'b0)
        $display("FAIL midreset_quiet_%0d: rvalid_p/rvalid_l/busy=%b required 000", k, {rvalid_p, rvalid_l, busy});
      else passed++;
    end
    req_p = 1; we_p = 1; addr_p = pool[5]; byteena_p = 32'hFFFF_FFFF; wdata_p = rand256();
    req_l = 1; we_l = 1; addr_l = pool[6]; byteena_l = 32'hFFFF_FFFF; wdata_l = rand256();
    tick();
    total++;
    if ({gnt_p, gnt_l} !== 2'b10)
      $display("FAIL midreset_first_tie: gnt_p/gnt_l=%b required 10", {gnt_p, gnt_l});
    else passed++;
    exp_mem[pool[5]] = wdata_p;
    last_p = 1;
    req_p = 0; req_l = 0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    rv_t               rvq[$];
    rv_t               r;
    int                free_at;
    bit                eg_p, eg_l, er_p, er_l, eb, ewe;
    logic [AW-1:0]     eaddr;
    logic [RAM_DW-1:0] ed;
    free_at = 0;
    req_p = 0; req_l = 0;
    for (int e = 0; e < 600; e++) begin
      tick();
      eg_p = 0; eg_l = 0; er_p = 0; er_l = 0; ed = '0; ewe = 0; eaddr = '0;
      if (e >= free_at && (req_p || req_l)) begin
        eg_p   = req_p && (!req_l || !last_p);
        eg_l   = !eg_p;
        last_p = eg_p;
        ewe    = eg_p ? we_p : we_l;
        eaddr  = eg_p ? addr_p : addr_l;
        if (ewe) begin
          exp_mem[eaddr] = eg_p ? merge(exp_mem[eaddr], wdata_p, byteena_p) : merge(exp_mem[eaddr], wdata_l, byteena_l);
          free_at = e + 2;
        end else begin
          r.edge_n = e + RD_LAT + 1;
          r.is_p   = eg_p;
          r.data   = exp_mem[eaddr];
          rvq.push_back(r);
          free_at = e + RD_LAT + 2;
        end
      end
      if (rvq.size() > 0 && rvq[0].edge_n == e) begin
        er_p = rvq[0].is_p;
        er_l = !rvq[0].is_p;
        ed   = rvq[0].data;
        void'(rvq.pop_front());
      end
      eb = (e + 1 < free_at);
      total++;
      if ({gnt_p, gnt_l, rvalid_p, rvalid_l, busy} !== {eg_p, eg_l, er_p, er_l, eb})
        $display("FAIL rand_ctl cyc %0d: gnt_p/gnt_l/rvalid_p/rvalid_l/busy=%b required %b",
                 e, {gnt_p, gnt_l, rvalid_p, rvalid_l, busy}, {eg_p, eg_l, er_p, er_l, eb});
      else passed++;
      if (eg_p || eg_l) begin
        total++;
        if (address_RAM !== eaddr || {wren_RAM, rden_RAM} !== {ewe, !ewe} ||
            byteena_RAM !== (ewe ? (eg_p ? byteena_p : byteena_l) : 32'hFFFF_FFFF))
          $display("FAIL rand_issue cyc %0d: addr=%h wren/rden=%b be=%h required addr=%h wren/rden=%b",
                   e, address_RAM, {wren_RAM, rden_RAM}, byteena_RAM, eaddr, {ewe, !ewe});
        else passed++;
      end
      if (er_p || er_l) begin
        total++;
        if (rdata !== ed)
          $display("FAIL rand_rdata cyc %0d: rdata=%h required %h", e, rdata, ed);
        else passed++;
      end
      if (eg_p) req_p = 0;
      else if (!req_p && $urandom_range(0, 2) != 0) begin
        req_p = 1; we_p = 1'($urandom_range(0, 1)); addr_p = pool[$urandom_range(0, 7)];
        byteena_p = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom; wdata_p = rand256();
      end
      if (eg_l) req_l = 0;
      else if (!req_l && $urandom_range(0, 2) != 0) begin
        req_l = 1; we_l = 1'($urandom_range(0, 1)); addr_l = pool[$urandom_range(0, 7)];
        byteena_l = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom; wdata_l = rand256();
      end
    end
    req_p = 0; req_l = 0;
    repeat (RD_LAT + 3) tick();
  endtask

`ifdef SIMD_ARB_PERF_EN
  task automatic test_perf();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    last_p = 0;
    total++;
    if (cnt_p !== 32'd0 || cnt_l !== 32'd0 || cnt_conflict !== 32'd0)
      $display("FAIL perf_reset: cnt_p=%0d cnt_l=%0d cnt_conflict=%0d required 0 0 0", cnt_p, cnt_l, cnt_conflict);
    else passed++;
    req_p = 1; we_p = 1; addr_p = pool[6]; byteena_p = 32'hFFFF_FFFF; wdata_p = rand256();
    req_l = 1; we_l = 1; addr_l = pool[7]; byteena_l = 32'hFFFF_FFFF; wdata_l = rand256();
    tick();
    exp_mem[pool[6]] = wdata_p;
    tick();
    req_p = 0;
    tick();
    exp_mem[pool[7]] = wdata_l;
    req_l = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      req_p = 1; wdata_p = rand256();
      tick();
      exp_mem[pool[6]] = wdata_p;
      req_p = 0;
      tick();
    end
    total++;
    if (cnt_p !== 32'd4 || cnt_l !== 32'd1 || cnt_conflict !== 32'd1)
      $display("FAIL perf_counts: cnt_p=%0d cnt_l=%0d cnt_conflict=%0d required 4 1 1", cnt_p, cnt_l, cnt_conflict);
    else passed++;
  endtask
`endif

  initial begin
    pool[0] = 14'h0010; pool[1] = 14'h0005; pool[2] = 14'h3FFF; pool[3] = 14'h0001;
    pool[4] = 14'h0002; pool[5] = 14'h0123; pool[6] = 14'h2AAA; pool[7] = 14'h1555;
    test_reset();
    test_write();
    test_preload();
    test_read();
    test_round_robin();
    test_byteena();
    test_reset_mid_read();
    test_random();
`ifdef SIMD_ARB_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
